// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer:
// M-extension func3 op codes, FSM state encoding and the default operand width.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi, lo} accumulator: shift-add for multiply,
// shift and trial-subtract (restoring) for divide. Purely combinational.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   sum;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, b_i};
    // Shifted partial remainder is XLEN+1 bits wide; the difference always fits XLEN when ge.
    ge    = acc_i[2*XLEN-1:XLEN-1] >= {1'b0, b_i};
    diff  = acc_i[2*XLEN-2:XLEN-1] - b_i;
    acc_o = acc_i;
    if (!is_div_i) begin
      if (acc_i[0]) acc_o = {sum, acc_i[XLEN-1:1]};
      else          acc_o = {1'b0, acc_i[2*XLEN-1:1]};
    end else if (ge) begin
      acc_o = {diff, acc_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {acc_i[2*XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer (IDLE -> CALC x XLEN -> DONE).
// Define MULDIV_EARLY_OUT_EN to send divide-by-zero / signed overflow straight to DONE.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 5
) (
  input  logic            clk_I,
  input  logic            rst_I,
  input  logic            start_I,
  input  logic [2:0]      func3_I,
  input  logic [XLEN-1:0] rs1_I,
  input  logic [XLEN-1:0] rs2_I,
  input  logic            flush_I,
  output logic            stall_O,
  output logic            busy_O,
  output logic            done_O,
  output logic [XLEN-1:0] result_O,
  output logic [1:0]      dbg_state_O
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   a_raw_q, a_raw_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              dz_q, dz_d, ovf_q, ovf_d;
  logic [XLEN-1:0]   result_q, result_d;

  op_e               op_in;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] step_acc, prod;
  logic [XLEN-1:0]   quo, rem, fixed;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (op_q[2]),
    .acc_i    (acc_q),
    .b_i      (b_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    op_in = op_e'(func3_I);
    a_neg = (op_in == OP_MULH || op_in == OP_MULHSU || op_in == OP_DIV || op_in == OP_REM)
            && rs1_I[XLEN-1];
    b_neg = (op_in == OP_MULH || op_in == OP_DIV || op_in == OP_REM) && rs2_I[XLEN-1];
    a_mag = a_neg ? -rs1_I : rs1_I;
    b_mag = b_neg ? -rs2_I : rs2_I;
  end

  // Sign fix-up and result select from the finished accumulator and the latched flags.
  always_comb begin
    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (dz_q) begin
      quo = '1;
      rem = a_raw_q;
    end else if (ovf_q) begin
      quo = INT_MIN;
      rem = '0;
    end
    case (op_q)
      OP_MUL:                      fixed = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fixed = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fixed = quo;
      default:                     fixed = rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    b_d      = b_q;
    a_raw_d  = a_raw_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start_I && !flush_I) begin
          op_d    = op_in;
          sa_d    = a_neg;
          sb_d    = b_neg;
          acc_d   = {{XLEN{1'b0}}, a_mag};
          b_d     = b_mag;
          a_raw_d = rs1_I;
          dz_d    = func3_I[2] && (rs2_I == '0);
          ovf_d   = (op_in == OP_DIV || op_in == OP_REM) && rs1_I == INT_MIN && rs2_I == '1;
          cnt_d   = '0;
`ifdef MULDIV_EARLY_OUT_EN
          state_d = (dz_d || ovf_d) ? ST_DONE : ST_CALC;
`else
          state_d = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        if (flush_I) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!flush_I) result_d = fixed;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_I) begin
    if (rst_I) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      acc_q    <= '0;
      b_q      <= '0;
      a_raw_q  <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      a_raw_q  <= a_raw_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  // The fresh result is forwarded in the DONE cycle so EX can take it with done_O.
  always_comb begin
    busy_O      = (state_q != ST_IDLE);
    stall_O     = ((state_q == ST_IDLE) && start_I && !flush_I) || (state_q == ST_CALC);
    done_O      = (state_q == ST_DONE) && !flush_I;
    result_O    = done_O ? fixed : result_q;
    dbg_state_O = state_q;
  end

endmodule
